// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding and
// the byte-enable width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: request-side enables/replication/legality
// and response-side load extension. LSU_MISALIGN_TRAP_EN enables misalign flagging.
module lsu_align
    import lsu_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [31:0]     wdata,
    input  logic [2:0]      rd_funct3,
    input  logic [1:0]      rd_lane,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_rep,
    output logic [31:0]     rdata_ext,
    output logic            illegal,
    output logic            misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Request side: byte enables, store-data replication and funct3 legality
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        illegal   = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    be        = 4'b0001 << lane;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be        = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: be = 4'b1111;
                default: illegal = 1'b1;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment is only reported for otherwise-legal encodings
    always_comb begin
        misalign = 1'b0;
        case (funct3)
            F3_H, F3_HU: misalign = lane[0] & ~illegal;
            F3_W:        misalign = (lane != 2'b00) & ~illegal;
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Response side: pick the addressed byte/half of the raw word
    always_comb begin
        byte_s = 8'h00;
        case (rd_lane)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = rd_lane[1] ? rdata[31:16] : rdata[15:0];
    end

    // Response side: sign or zero extension by funct3
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (rd_funct3)
            F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'h00_0000, byte_s};
            F3_HU:   rdata_ext = {16'h0000, half_s};
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// RV32I load/store unit: request/grant/response handshake to data memory with
// timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_misalign,
    output logic            busy,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [BE_W-1:0] mem_be,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t      state_r, state_s;
    logic            we_r;
    logic [2:0]      f3_r;
    logic [1:0]      lane_r;
    logic [TW-1:0]   tcnt_r;
    logic            tout_s;
    logic            bad_s;
    logic [BE_W-1:0] be_s;
    logic [31:0]     wdata_rep_s;
    logic [31:0]     rdata_ext_s;
    logic            illegal_s;
    logic            misalign_s;

    lsu_align u_align (
        .we        (req_we),
        .funct3    (req_funct3),
        .lane      (req_addr[1:0]),
        .wdata     (req_wdata),
        .rd_funct3 (f3_r),
        .rd_lane   (lane_r),
        .rdata     (mem_rdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s),
        .illegal   (illegal_s),
        .misalign  (misalign_s)
    );

    // The counter value during the Nth cycle in REQ/WAIT is N-1, so the last
    // allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign tout_s = (tcnt_r == TW'(TIMEOUT_CYCLES - 1));
    assign bad_s  = illegal_s | misalign_s;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    state_s = bad_s ? S_RESP : S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (tout_s) begin
                    state_s = S_RESP;
                end else if (mem_gnt) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || tout_s) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, request latches, memory-side and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            we_r         <= 1'b0;
            f3_r         <= 3'b000;
            lane_r       <= 2'b00;
            tcnt_r       <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= 32'h0000_0000;
            mem_wdata    <= 32'h0000_0000;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            req_ready    <= (state_s == S_IDLE);
            busy         <= (state_s != S_IDLE);
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        f3_r      <= req_funct3;
                        lane_r    <= req_addr[1:0];
                        tcnt_r    <= '0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_rep_s;
                        if (bad_s) begin
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_misalign <= misalign_s;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= req_we;
                            mem_be  <= be_s;
                        end
                    end else begin
                        tcnt_r <= tcnt_r;
                    end
                end
                S_REQ: begin
                    tcnt_r <= tcnt_r + TW'(1);
                    if (tout_s || mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        rsp_valid <= tout_s;
                        rsp_err   <= tout_s;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    tcnt_r <= tcnt_r + TW'(1);
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_r ? 32'h0000_0000 : rdata_ext_s;
                    end else if (tout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b0;
                    end
                end
                S_RESP: begin
                    tcnt_r <= tcnt_r;
                end
                default: begin
                    tcnt_r <= '0;
                end
            endcase
        end
    end

endmodule
